// File: rtl/snake_pkg.sv
// Shared types and helpers for the LED-matrix snake game core.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    FOOD = 3'd2,
    RUN  = 3'd3,
    OVER = 3'd4
  } state_t;

  // Direction that would reverse the snake onto its own neck.
  function automatic dir_t opposite(dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  // Flat pixel-map bit index for cell (x, y), row-major.
  function automatic int unsigned idx(int unsigned x, int unsigned y, int unsigned cols);
    return y * cols + x;
  endfunction

endpackage

// File: rtl/snake_body_buf.sv
// Circular buffer of snake body cells; push adds the new head, pop drops the tail.
module snake_body_buf #(
  parameter  int MAX_LEN = 32,
  parameter  int W       = 7,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  tail_data,
  output logic [CW-1:0] count
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(MAX_LEN - 1);

  logic [W-1:0]  r_mem [MAX_LEN];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  // Push is accepted when full only if the tail leaves in the same cycle.
  always_comb begin
    w_full    = (r_count == CW'(MAX_LEN));
    w_do_pop  = pop && (r_count != '0);
    w_do_push = push && (!w_full || w_do_pop);
  end

  // Storage write; contents need no reset because count qualifies them.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == LAST) ? '0 : r_wr + PW'(1);
      if (w_do_pop)  r_rd <= (r_rd == LAST) ? '0 : r_rd + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign tail_data = r_mem[r_rd];
  assign count     = r_count;

endmodule

// File: rtl/snake_engine.sv
// Snake game core: FSM, direction buffer, movement/collision and pixel map.
module snake_engine
  import snake_pkg::*;
#(
  parameter  int COLS      = 16,
  parameter  int ROWS      = 8,
  parameter  int MAX_LEN   = 32,
  parameter  int START_LEN = 3,
  parameter  int WRAP      = 1,
  localparam int X_W       = $clog2(COLS),
  localparam int Y_W       = $clog2(ROWS),
  localparam int LW        = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 step,
  input  logic [X_W-1:0]       rand_x,
  input  logic [Y_W-1:0]       rand_y,
  output logic                 food_req,
  output logic [COLS*ROWS-1:0] pixel_reg,
  output logic [X_W-1:0]       head_x,
  output logic [Y_W-1:0]       head_y,
  output logic [LW-1:0]        length,
  output logic [7:0]           score,
  output logic                 game_over
);

  localparam int N  = COLS * ROWS;
  localparam int IW = $clog2(N);
  localparam int BW = X_W + Y_W;

  state_t         r_state;
  dir_t           r_dir;
  dir_t           r_pend;
  logic [X_W-1:0] r_head_x;
  logic [Y_W-1:0] r_head_y;
  logic [X_W-1:0] r_food_x;
  logic [Y_W-1:0] r_food_y;
  logic [N-1:0]   r_map;
  logic [7:0]     r_score;
  logic           r_food_req;
  logic           r_game_over;
  logic [LW-1:0]  r_init_cnt;

  dir_t           w_req;
  dir_t           w_eff;
  logic           w_btn_ok;
  logic [X_W-1:0] w_next_x;
  logic [Y_W-1:0] w_next_y;
  logic [X_W-1:0] w_seg_x;
  logic [Y_W-1:0] w_seg_y;
  logic [X_W-1:0] w_tail_x;
  logic [Y_W-1:0] w_tail_y;
  logic [IW-1:0]  w_next_i;
  logic [IW-1:0]  w_seg_i;
  logic [IW-1:0]  w_tail_i;
  logic [IW-1:0]  w_rand_i;
  logic           w_oob;
  logic           w_eat;
  logic           w_collide;
  logic           w_move;
  logic           w_full;
  logic           w_rand_ok;
  logic           w_push;
  logic           w_pop;
  logic           w_clear;
  logic [BW-1:0]  w_push_data;
  logic [BW-1:0]  w_tail_data;
  logic [LW-1:0]  w_count;

  snake_body_buf #(
    .MAX_LEN (MAX_LEN),
    .W       (BW)
  ) u_body (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .tail_data (w_tail_data),
    .count     (w_count)
  );

  // Next-head computation, collision test and body-buffer control.
  always_comb begin
    int nx;
    int ny;
    w_req = RIGHT;
    if (btn_up)        w_req = UP;
    else if (btn_down) w_req = DOWN;
    else if (btn_left) w_req = LEFT;
    w_btn_ok = (btn_up || btn_down || btn_left || btn_right) && (w_req != opposite(r_dir));
    // A button in the same cycle as step applies to that step.
    w_eff = w_btn_ok ? w_req : r_pend;

    nx = int'(r_head_x);
    ny = int'(r_head_y);
    case (w_eff)
      UP:      ny = ny - 1;
      DOWN:    ny = ny + 1;
      LEFT:    nx = nx - 1;
      default: nx = nx + 1;
    endcase
    w_oob = 1'b0;
    if (WRAP != 0) begin
      nx = (nx + COLS) % COLS;
      ny = (ny + ROWS) % ROWS;
    end else begin
      w_oob = (nx < 0) || (nx >= COLS) || (ny < 0) || (ny >= ROWS);
    end
    w_next_x = X_W'(nx);
    w_next_y = Y_W'(ny);
    w_next_i = IW'(idx(32'(w_next_x), 32'(w_next_y), COLS));

    w_tail_x = w_tail_data[BW-1:Y_W];
    w_tail_y = w_tail_data[Y_W-1:0];
    w_tail_i = IW'(idx(32'(w_tail_x), 32'(w_tail_y), COLS));

    w_seg_x = X_W'(COLS / 2 - START_LEN + 1 + int'(r_init_cnt));
    w_seg_y = Y_W'(ROWS / 2);
    w_seg_i = IW'(idx(32'(w_seg_x), 32'(w_seg_y), COLS));

    w_rand_i  = IW'(idx(32'(rand_x), 32'(rand_y), COLS));
    w_rand_ok = (32'(rand_x) < 32'(COLS)) && (32'(rand_y) < 32'(ROWS)) && !r_map[w_rand_i];

    // The map holds body plus food: food and the vacating tail are not obstacles.
    w_eat     = (w_next_x == r_food_x) && (w_next_y == r_food_y);
    w_collide = w_oob || (r_map[w_next_i] && !w_eat && ({w_next_x, w_next_y} != w_tail_data));
    w_move    = (r_state == RUN) && step && !w_collide;
    w_full    = (w_count == LW'(MAX_LEN));

    w_clear     = ((r_state == IDLE) || (r_state == OVER)) && start;
    w_push      = (r_state == INIT) || w_move;
    w_pop       = w_move && (!w_eat || w_full);
    w_push_data = (r_state == INIT) ? {w_seg_x, w_seg_y} : {w_next_x, w_next_y};
  end

  // Game FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dir       <= RIGHT;
      r_pend      <= RIGHT;
      r_head_x    <= '0;
      r_head_y    <= '0;
      r_food_x    <= '0;
      r_food_y    <= '0;
      r_map       <= '0;
      r_score     <= '0;
      r_food_req  <= 1'b0;
      r_game_over <= 1'b0;
      r_init_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE, OVER: begin
          if (start) begin
            r_state     <= INIT;
            r_map       <= '0;
            r_score     <= '0;
            r_game_over <= 1'b0;
            r_init_cnt  <= '0;
            r_dir       <= RIGHT;
            r_pend      <= RIGHT;
          end
        end
        INIT: begin
          r_map[w_seg_i] <= 1'b1;
          r_head_x       <= w_seg_x;
          r_head_y       <= w_seg_y;
          r_init_cnt     <= r_init_cnt + LW'(1);
          if (r_init_cnt == LW'(START_LEN - 1)) begin
            r_state    <= FOOD;
            r_food_req <= 1'b1;
          end
        end
        FOOD: begin
          // Request cycle, then sample cycle; a rejected candidate re-requests.
          if (r_food_req) begin
            r_food_req <= 1'b0;
          end else if (w_rand_ok) begin
            r_food_x        <= rand_x;
            r_food_y        <= rand_y;
            r_map[w_rand_i] <= 1'b1;
            r_state         <= RUN;
          end else begin
            r_food_req <= 1'b1;
          end
        end
        RUN: begin
          if (w_btn_ok) r_pend <= w_req;
          if (step) begin
            r_dir  <= w_eff;
            r_pend <= w_eff;
            if (w_collide) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              // Tail clear precedes head set so moving onto the tail cell keeps it lit.
              if (w_pop) r_map[w_tail_i] <= 1'b0;
              r_map[w_next_i] <= 1'b1;
              r_head_x        <= w_next_x;
              r_head_y        <= w_next_y;
              if (w_eat) begin
                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                r_state    <= FOOD;
                r_food_req <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign food_req  = r_food_req;
  assign pixel_reg = r_map;
  assign head_x    = r_head_x;
  assign head_y    = r_head_y;
  assign length    = w_count;
  assign score     = r_score;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a wrapping and a walled instance share stimulus and
// are each compared every cycle against a queue-style model of the game rules.
module tb_snake_engine;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int MAX_LEN = 32;
  localparam int START_LEN = 3;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int LW = 6;
  localparam int NP = COLS * ROWS;

  localparam int P_IDLE = 0, P_INIT = 1, P_FREQ = 2, P_FSAMP = 3, P_RUN = 4, P_OVER = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic          step = 1'b0;
  logic [XW-1:0] rx = '0;
  logic [YW-1:0] ry = '0;

  logic          o_freq [2];
  logic [NP-1:0] o_pix  [2];
  logic [XW-1:0] o_hx   [2];
  logic [YW-1:0] o_hy   [2];
  logic [LW-1:0] o_len  [2];
  logic [7:0]    o_sc   [2];
  logic          o_ov   [2];

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  snake_engine #(.COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .btn_up(bu), .btn_down(bd), .btn_left(bl),
    .btn_right(br), .step(step), .rand_x(rx), .rand_y(ry), .food_req(o_freq[0]),
    .pixel_reg(o_pix[0]), .head_x(o_hx[0]), .head_y(o_hy[0]), .length(o_len[0]),
    .score(o_sc[0]), .game_over(o_ov[0]));

  snake_engine #(.COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .WRAP(0)) u_wall (
    .clk(clk), .reset(reset), .start(start), .btn_up(bu), .btn_down(bd), .btn_left(bl),
    .btn_right(br), .step(step), .rand_x(rx), .rand_y(ry), .food_req(o_freq[1]),
    .pixel_reg(o_pix[1]), .head_x(o_hx[1]), .head_y(o_hy[1]), .length(o_len[1]),
    .score(o_sc[1]), .game_over(o_ov[1]));

  // Model state: body arrays hold cells tail-first (index 0 = tail, bn-1 = head).
  // Directions as plain numbers 0 up, 1 down, 2 left, 3 right; reverse = d ^ 1.
  int bx [2][MAX_LEN+1];
  int by [2][MAX_LEN+1];
  int bn [2] = '{0, 0};
  int ph [2] = '{P_IDLE, P_IDLE};
  int dir [2] = '{3, 3};
  int pend [2] = '{3, 3};
  int fx [2] = '{0, 0};
  int fy [2] = '{0, 0};
  bit fv [2] = '{0, 0};
  int sc [2] = '{0, 0};
  bit fr [2] = '{0, 0};
  bit ov [2] = '{0, 0};
  int hx [2] = '{0, 0};
  int hy [2] = '{0, 0};
  int ik [2] = '{0, 0};

  task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit on_body(input int i, input int x, input int y, input int from);
    for (int k = from; k < bn[i]; k++)
      if (bx[i][k] == x && by[i][k] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NP-1:0] exp_map(input int i);
    logic [NP-1:0] m;
    m = '0;
    for (int k = 0; k < bn[i]; k++) m[by[i][k] * COLS + bx[i][k]] = 1'b1;
    if (fv[i]) m[fy[i] * COLS + fx[i]] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input int i);
    int nx, ny, req;
    bit any, eat, grow, oob;
    if (reset) begin
      ph[i] = P_IDLE; bn[i] = 0; fv[i] = 0; sc[i] = 0; fr[i] = 0; ov[i] = 0;
      hx[i] = 0; hy[i] = 0; dir[i] = 3; pend[i] = 3;
    end else begin
      case (ph[i])
        P_IDLE, P_OVER: if (start) begin
          ph[i] = P_INIT; ik[i] = 0; bn[i] = 0; fv[i] = 0; sc[i] = 0; ov[i] = 0;
          dir[i] = 3; pend[i] = 3;
        end
        P_INIT: begin
          hx[i] = COLS / 2 - START_LEN + 1 + ik[i];
          hy[i] = ROWS / 2;
          bx[i][bn[i]] = hx[i]; by[i][bn[i]] = hy[i]; bn[i]++;
          ik[i]++;
          if (ik[i] == START_LEN) begin ph[i] = P_FREQ; fr[i] = 1; end
        end
        P_FREQ: begin fr[i] = 0; ph[i] = P_FSAMP; end
        P_FSAMP: begin
          if (int'(rx) < COLS && int'(ry) < ROWS && !on_body(i, int'(rx), int'(ry), 0)) begin
            fx[i] = int'(rx); fy[i] = int'(ry); fv[i] = 1; ph[i] = P_RUN;
          end else begin
            fr[i] = 1; ph[i] = P_FREQ;
          end
        end
        P_RUN: begin
          any = bu | bd | bl | br;
          req = bu ? 0 : bd ? 1 : bl ? 2 : 3;
          if (any && req != (dir[i] ^ 1)) pend[i] = req;
          if (step) begin
            dir[i] = pend[i];
            nx = hx[i] + (dir[i] == 3 ? 1 : 0) - (dir[i] == 2 ? 1 : 0);
            ny = hy[i] + (dir[i] == 1 ? 1 : 0) - (dir[i] == 0 ? 1 : 0);
            oob = (nx < 0 || nx >= COLS || ny < 0 || ny >= ROWS);
            if (i == 0) begin
              nx = (nx + COLS) % COLS;
              ny = (ny + ROWS) % ROWS;
              oob = 0;
            end
            eat = fv[i] && nx == fx[i] && ny == fy[i];
            grow = eat && bn[i] < MAX_LEN;
            if (oob || on_body(i, nx, ny, grow ? 0 : 1)) begin
              ph[i] = P_OVER; ov[i] = 1;
            end else begin
              if (!grow) begin
                for (int k = 0; k < bn[i] - 1; k++) begin
                  bx[i][k] = bx[i][k+1]; by[i][k] = by[i][k+1];
                end
                bn[i]--;
              end
              bx[i][bn[i]] = nx; by[i][bn[i]] = ny; bn[i]++;
              hx[i] = nx; hy[i] = ny;
              if (eat) begin
                if (sc[i] < 255) sc[i]++;
                fv[i] = 0; ph[i] = P_FREQ; fr[i] = 1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_edge(i);
    if (reset) armed = 1'b1;
  end

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.pixel_reg", i), o_pix[i], exp_map(i));
        chk($sformatf("u%0d.head_x", i), NP'(o_hx[i]), NP'(hx[i]));
        chk($sformatf("u%0d.head_y", i), NP'(o_hy[i]), NP'(hy[i]));
        chk($sformatf("u%0d.length", i), NP'(o_len[i]), NP'(bn[i]));
        chk($sformatf("u%0d.score", i), NP'(o_sc[i]), NP'(sc[i]));
        chk($sformatf("u%0d.game_over", i), NP'(o_ov[i]), NP'(ov[i]));
        chk($sformatf("u%0d.food_req", i), NP'(o_freq[i]), NP'(fr[i]));
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic pb(input int i, input int x, input int y);
    return o_pix[i][y * COLS + x];
  endfunction

  task automatic begin_game(input int fx0, input int fy0);
    start = 1'b1; tick(); start = 1'b0;
    tick(START_LEN);
    rx = XW'(fx0); ry = YW'(fy0);
    tick(2);
  endtask

  task automatic press_step(input int d);
    bu = (d == 0); bd = (d == 1); bl = (d == 2); br = (d == 3);
    step = 1'b1; tick();
    bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0; step = 1'b0;
  endtask

  logic [NP-1:0] frozen;

  initial begin
    tick(2);
    reset = 1'b0;
    chk("lit.reset_pix", o_pix[0], '0);
    chk("lit.reset_len", NP'(o_len[0]), NP'(0));
    chk("lit.reset_freq", NP'(o_freq[0]), NP'(0));

    // Start: three INIT cycles lay (6,4),(7,4),(8,4).
    start = 1'b1; tick(); start = 1'b0;
    tick(3);
    chk("lit.init_px6", NP'(pb(0, 6, 4)), NP'(1));
    chk("lit.init_px7", NP'(pb(0, 7, 4)), NP'(1));
    chk("lit.init_px8", NP'(pb(0, 8, 4)), NP'(1));
    chk("lit.init_head_x", NP'(o_hx[0]), NP'(8));
    chk("lit.init_len", NP'(o_len[0]), NP'(3));
    chk("lit.init_freq", NP'(o_freq[0]), NP'(1));
    // First candidate lies on the body and must be re-requested.
    rx = 4'd7; ry = 3'd4;
    tick(2);
    chk("lit.reject_freq", NP'(o_freq[0]), NP'(1));
    rx = 4'd10; ry = 3'd4;
    step = 1'b1; tick(); step = 1'b0;
    tick();
    chk("lit.food_px", NP'(pb(0, 10, 4)), NP'(1));
    chk("lit.food_step_dropped", NP'(o_hx[0]), NP'(8));
    // Reverse request is ignored; snake keeps moving right.
    press_step(2);
    chk("lit.move_head", NP'(o_hx[0]), NP'(9));
    chk("lit.tail_cleared", NP'(pb(0, 6, 4)), NP'(0));
    press_step(3);
    chk("lit.eat_len", NP'(o_len[0]), NP'(4));
    chk("lit.eat_score", NP'(o_sc[0]), NP'(1));
    chk("lit.eat_tail_kept", NP'(pb(0, 7, 4)), NP'(1));
    chk("lit.eat_freq", NP'(o_freq[0]), NP'(1));
    rx = 4'd2; ry = 3'd2;
    tick(2);
    step = 1'b1; tick(5); step = 1'b0;
    chk("lit.edge_head", NP'(o_hx[1]), NP'(15));
    frozen = o_pix[1];
    press_step(3);
    chk("lit.wrap_head", NP'(o_hx[0]), NP'(0));
    chk("lit.wall_over", NP'(o_ov[1]), NP'(1));
    chk("lit.wall_frozen", o_pix[1], frozen);
    tick(3);
    chk("lit.wall_still_frozen", o_pix[1], frozen);

    // Reset in the middle of a running game.
    reset = 1'b1; tick(); reset = 1'b0;
    chk("lit.midreset_pix", o_pix[0], '0);
    chk("lit.midreset_head", NP'(o_hx[0]), NP'(0));
    chk("lit.midreset_score", NP'(o_sc[0]), NP'(0));

    // Grow to five, then curl into the middle of the body.
    begin_game(9, 4);
    press_step(3);
    rx = 4'd10; ry = 3'd4; tick(2);
    press_step(3);
    rx = 4'd0; ry = 3'd0; tick(2);
    chk("lit.len5", NP'(o_len[0]), NP'(5));
    press_step(0);
    press_step(2);
    press_step(1);
    chk("lit.self_hit_over", NP'(o_ov[0]), NP'(1));
    chk("lit.self_hit_len", NP'(o_len[0]), NP'(5));

    // Length four loop: moving onto the vacating tail is legal.
    begin_game(9, 4);
    press_step(3);
    rx = 4'd0; ry = 3'd0; tick(2);
    press_step(0);
    press_step(2);
    press_step(1);
    chk("lit.tail_move_over", NP'(o_ov[0]), NP'(0));
    chk("lit.tail_move_head_x", NP'(o_hx[0]), NP'(8));
    chk("lit.tail_move_head_y", NP'(o_hy[0]), NP'(4));
    chk("lit.tail_move_px", NP'(pb(0, 8, 4)), NP'(1));

    // Randomized play.
    for (int c = 0; c < 8000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      start = ($urandom_range(0, 19) == 0);
      step  = ($urandom_range(0, 2) == 0);
      bu = ($urandom_range(0, 5) == 0);
      bd = ($urandom_range(0, 5) == 0);
      bl = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 5) == 0);
      rx = XW'($urandom);
      ry = YW'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; step = 1'b0;
    bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
